loopyv_pipeline_controller: RTL and testbench
=============================================

// Module: loopyv_pipeline_controller
// PURPOSE
// Hazard and sequencing controller for the 5-stage RV32IMC pipeline (IF/DE/EX/MEM/WB).
// - Generates per-stage stall (hold register) and flush (load bubble) controls.
// - Generates operand forwarding selects for the DE->EX operands.
// - Sequences multi-cycle waits for the data memory and the mul/div unit, with a
//   memory timeout that raises a sticky bus error.
// PARAMETERS
// TIMEOUT_W  8  width of memory-wait counter; timeout after 2**TIMEOUT_W-1 wait cycles
// PORTS
// clk             in   1  clock, rising edge
// reset           in   1  asynchronous, active-high reset
// deRs1Addr       in   5  rs1 of instruction in DE
// deRs2Addr       in   5  rs2 of instruction in DE
// deUsesRs1       in   1  DE instruction reads rs1
// deUsesRs2       in   1  DE instruction reads rs2
// exRdAddr        in   5  rd of ID/EX register
// exRdWriteEn     in   1  ID/EX writes rd
// exLoadSignal    in   1  ID/EX holds a load
// exBranchTaken   in   1  EX resolved a taken branch/jump (PC redirect)
// exMulDivStart   in   1  EX holds an M-extension op needing the multi-cycle unit
// mulDivDone      in   1  mul/div result valid this cycle
// memRdAddr       in   5  rd of EX/MEM register
// memRdWriteEn    in   1  EX/MEM writes rd
// memAccess       in   1  EX/MEM holds a load or store
// dmemRvalid      in   1  data memory completes the access this cycle
// wbRdAddr        in   5  rd of MEM/WB register
// wbRdWriteEn     in   1  MEM/WB writes rd
// stallIF         out  1  hold PC
// stallDE         out  1  hold IF/DE register
// stallEX         out  1  hold ID/EX register
// stallMEM        out  1  hold EX/MEM and MEM/WB registers
// flushDE         out  1  clear IF/DE register to bubble
// flushEX         out  1  clear ID/EX register to bubble
// flushMEM        out  1  clear EX/MEM register to bubble
// fwdASelect      out  2  operand A: 00 regfile, 01 EX/MEM rdWriteData, 10 MEM/WB rdWriteData
// fwdBSelect      out  2  operand B: same encoding
// busError        out  1  sticky memory-timeout flag
// ctrlState       out  2  FSM state (debug)
// BEHAVIOUR
// - FSM states: RUN=00, MEM_WAIT=01, MULDIV_WAIT=10, ERROR=11. Only state, counter and
//   busError are registered; all stall/flush/fwd outputs are combinational (0-cycle).
// - Reset (async): state=RUN, counter=0, busError=0. While reset is high: all
//   flush*=1, all stall*=0, fwd*=00.
// - Forwarding (any state): src matches memRdAddr & memRdWriteEn -> 01; else matches
//   wbRdAddr & wbRdWriteEn -> 10; else 00. Address x0 never forwarded. MEM beats WB.
// - Priority of pipeline-control sources within RUN, highest first:
//   1 memory wait: memAccess & !dmemRvalid -> all stall*=1, no flush; next=MEM_WAIT, counter=1.
//   2 branch: exBranchTaken -> flushDE=1, flushEX=1; any load-use/muldiv ignored this cycle.
//   3 mul/div: exMulDivStart & !mulDivDone -> stallIF/DE/EX=1, flushMEM=1; next=MULDIV_WAIT.
//   4 load-use: exLoadSignal & exRdWriteEn & exRdAddr!=0 & ((deUsesRs1 & deRs1Addr==exRdAddr)
//     | (deUsesRs2 & deRs2Addr==exRdAddr)) -> stallIF=1, stallDE=1, flushEX=1 (one bubble).
//   5 otherwise all stall*/flush*=0.
// - MEM_WAIT: all stall*=1 and flush*=0 until dmemRvalid. On dmemRvalid: stalls release
//   in the same cycle; RUN rules (2-4) apply that cycle; next=RUN. Counter increments
//   each wait cycle. If counter reaches 2**TIMEOUT_W-1 with no dmemRvalid: next=ERROR.
//   exBranchTaken/exMulDivStart are ignored while frozen and are re-evaluated on release.
// - MULDIV_WAIT: stallIF/DE/EX=1, flushMEM=1 each cycle. On mulDivDone: release same
//   cycle, next=RUN. A memAccess & !dmemRvalid arising is impossible (MEM holds bubbles).
// - ERROR: busError=1 (sticky), all stall*=1, flush*=0; left only by reset.
// - Reset mid-wait: returns to RUN immediately; counter cleared; busError cleared.
// TESTING
// 1 lw x5 then add x6,x5,x1: exactly one cycle stallIF=stallDE=flushEX=1, then fwdASelect=10.
// 2 add x5; add x7,x5,x5 back-to-back -> fwdA=fwdB=01; rd=x0 producer -> fwd 00.
// 3 taken branch with load-use on same cycle -> flushDE=flushEX=1, stallIF=0, no extra bubble.
// 4 load, dmemRvalid low 3 cycles -> all stalls high 3 cycles, state 01, release cycle 4.
// 5 TIMEOUT_W=4, dmemRvalid never -> ERROR after 15 wait cycles, busError=1 until reset.
// 6 div with mulDivDone after 33 cycles -> 33 cycles stall+flushMEM, state 10, then RUN.

Source files
------------

// File: rtl/loopyv_pipeline_controller.sv
// loopyv_pipeline_controller
// Hazard and sequencing controller for the 5-stage RV32IMC pipeline.
//   - per-stage stall (hold) and flush (bubble) controls, combinational
//   - DE->EX operand forwarding selects (00 regfile, 01 EX/MEM, 10 MEM/WB)
//   - multi-cycle sequencing for data memory and mul/div waits; a memory
//     wait lasting 2**TIMEOUT_W-1 cycles locks into ERROR with a sticky busError
// Ports:
//   clk, reset                     clock (rising), async active-high reset
//   de*/ex*/mem*/wb* inputs        hazard sources from each pipeline register
//   mulDivDone, dmemRvalid         completion strobes of the multi-cycle units
//   stall{IF,DE,EX,MEM}            hold controls
//   flush{DE,EX,MEM}               load-bubble controls
//   fwdASelect, fwdBSelect         operand forwarding selects
//   busError                       sticky memory timeout flag
//   ctrlState                      FSM state (debug)
module loopyv_pipeline_controller #(
  parameter int TIMEOUT_W = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] deRs1Addr,
  input  logic [4:0] deRs2Addr,
  input  logic       deUsesRs1,
  input  logic       deUsesRs2,
  input  logic [4:0] exRdAddr,
  input  logic       exRdWriteEn,
  input  logic       exLoadSignal,
  input  logic       exBranchTaken,
  input  logic       exMulDivStart,
  input  logic       mulDivDone,
  input  logic [4:0] memRdAddr,
  input  logic       memRdWriteEn,
  input  logic       memAccess,
  input  logic       dmemRvalid,
  input  logic [4:0] wbRdAddr,
  input  logic       wbRdWriteEn,
  output logic       stallIF,
  output logic       stallDE,
  output logic       stallEX,
  output logic       stallMEM,
  output logic       flushDE,
  output logic       flushEX,
  output logic       flushMEM,
  output logic [1:0] fwdASelect,
  output logic [1:0] fwdBSelect,
  output logic       busError,
  output logic [1:0] ctrlState
);

  typedef enum logic [1:0] {
    RUN         = 2'b00,
    MEM_WAIT    = 2'b01,
    MULDIV_WAIT = 2'b10,
    ERROR       = 2'b11
  } state_t;

  state_t               state, stateNext;
  logic [TIMEOUT_W-1:0] cnt, cntNext;

  // Stall/flush bundle: {IF, DE, EX, MEM} stalls and {DE, EX, MEM} flushes.
  typedef struct packed {
    logic sIF, sDE, sEX, sMEM;
    logic fDE, fEX, fMEM;
  } ctl_t;

  localparam ctl_t CTL_NONE   = '0;
  localparam ctl_t CTL_FREEZE = '{sIF: 1'b1, sDE: 1'b1, sEX: 1'b1, sMEM: 1'b1,
                                   fDE: 1'b0, fEX: 1'b0, fMEM: 1'b0};
  localparam ctl_t CTL_MULDIV = '{sIF: 1'b1, sDE: 1'b1, sEX: 1'b1, sMEM: 1'b0,
                                   fDE: 1'b0, fEX: 1'b0, fMEM: 1'b1};

  ctl_t runCtl, ctl;
  logic runMulDiv;
  logic memStall, loadUse;

  function automatic logic [1:0] fwdSel(
    input logic [4:0] src,
    input logic [4:0] mAddr, input logic mWe,
    input logic [4:0] wAddr, input logic wWe
  );
    if (src != 5'd0 && mWe && src == mAddr)      fwdSel = 2'b01;
    else if (src != 5'd0 && wWe && src == wAddr) fwdSel = 2'b10;
    else                                         fwdSel = 2'b00;
  endfunction

  assign memStall = memAccess & ~dmemRvalid;
  assign loadUse  = exLoadSignal & exRdWriteEn & (exRdAddr != 5'd0) &
                    ((deUsesRs1 & (deRs1Addr == exRdAddr)) |
                     (deUsesRs2 & (deRs2Addr == exRdAddr)));

  // Branch / mul-div / load-use priority, shared by RUN and the MEM_WAIT
  // release cycle. A taken branch squashes the DE instruction, so any
  // load-use or mul-div it would have caused is moot.
  always_comb begin
    runCtl    = CTL_NONE;
    runMulDiv = 1'b0;
    if (exBranchTaken) begin
      runCtl.fDE = 1'b1;
      runCtl.fEX = 1'b1;
    end else if (exMulDivStart & ~mulDivDone) begin
      runCtl    = CTL_MULDIV;
      runMulDiv = 1'b1;
    end else if (loadUse) begin
      runCtl.sIF = 1'b1;
      runCtl.sDE = 1'b1;
      runCtl.fEX = 1'b1;
    end
  end

  always_comb begin
    ctl       = CTL_NONE;
    stateNext = state;
    cntNext   = cnt;
    case (state)
      RUN: begin
        if (memStall) begin
          ctl       = CTL_FREEZE;
          stateNext = MEM_WAIT;
          cntNext   = TIMEOUT_W'(1);
        end else begin
          ctl = runCtl;
          if (runMulDiv) stateNext = MULDIV_WAIT;
        end
      end
      MEM_WAIT: begin
        if (dmemRvalid) begin
          ctl       = runCtl;
          stateNext = RUN;
          cntNext   = '0;
        end else begin
          ctl     = CTL_FREEZE;
          cntNext = cnt + TIMEOUT_W'(1);
          if (cntNext == '1) stateNext = ERROR;
        end
      end
      MULDIV_WAIT: begin
        if (mulDivDone) stateNext = RUN;
        else            ctl       = CTL_MULDIV;
      end
      ERROR: ctl = CTL_FREEZE;
      default: stateNext = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      cnt      <= '0;
      busError <= 1'b0;
    end else begin
      state    <= stateNext;
      cnt      <= cntNext;
      busError <= busError | (stateNext == ERROR);
    end
  end

  // Reset forces bubbles into every stage while holding nothing.
  always_comb begin
    {stallIF, stallDE, stallEX, stallMEM} = {ctl.sIF, ctl.sDE, ctl.sEX, ctl.sMEM};
    {flushDE, flushEX, flushMEM}          = {ctl.fDE, ctl.fEX, ctl.fMEM};
    fwdASelect = fwdSel(deRs1Addr, memRdAddr, memRdWriteEn, wbRdAddr, wbRdWriteEn);
    fwdBSelect = fwdSel(deRs2Addr, memRdAddr, memRdWriteEn, wbRdAddr, wbRdWriteEn);
    if (reset) begin
      {stallIF, stallDE, stallEX, stallMEM} = 4'b0000;
      {flushDE, flushEX, flushMEM}          = 3'b111;
      fwdASelect = 2'b00;
      fwdBSelect = 2'b00;
    end
  end

  assign ctrlState = state;

endmodule

// File: tb/tb_loopyv_pipeline_controller.sv
module tb_loopyv_pipeline_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] deRs1Addr, deRs2Addr, exRdAddr, memRdAddr, wbRdAddr;
  logic       deUsesRs1, deUsesRs2, exRdWriteEn, exLoadSignal, exBranchTaken;
  logic       exMulDivStart, mulDivDone, memRdWriteEn, memAccess, dmemRvalid, wbRdWriteEn;
  logic       stallIF, stallDE, stallEX, stallMEM, flushDE, flushEX, flushMEM;
  logic [1:0] fwdASelect, fwdBSelect, ctrlState;
  logic       busError;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  loopyv_pipeline_controller #(.TIMEOUT_W(4)) dut (
    .clk(clk), .reset(reset),
    .deRs1Addr(deRs1Addr), .deRs2Addr(deRs2Addr),
    .deUsesRs1(deUsesRs1), .deUsesRs2(deUsesRs2),
    .exRdAddr(exRdAddr), .exRdWriteEn(exRdWriteEn), .exLoadSignal(exLoadSignal),
    .exBranchTaken(exBranchTaken), .exMulDivStart(exMulDivStart), .mulDivDone(mulDivDone),
    .memRdAddr(memRdAddr), .memRdWriteEn(memRdWriteEn), .memAccess(memAccess),
    .dmemRvalid(dmemRvalid), .wbRdAddr(wbRdAddr), .wbRdWriteEn(wbRdWriteEn),
    .stallIF(stallIF), .stallDE(stallDE), .stallEX(stallEX), .stallMEM(stallMEM),
    .flushDE(flushDE), .flushEX(flushEX), .flushMEM(flushMEM),
    .fwdASelect(fwdASelect), .fwdBSelect(fwdBSelect),
    .busError(busError), .ctrlState(ctrlState)
  );

  // {stallIF, stallDE, stallEX, stallMEM, flushDE, flushEX, flushMEM}
  wire [6:0] ctl = {stallIF, stallDE, stallEX, stallMEM, flushDE, flushEX, flushMEM};

  localparam logic [6:0] C_NONE   = 7'b0000_000;
  localparam logic [6:0] C_RST    = 7'b0000_111;
  localparam logic [6:0] C_FREEZE = 7'b1111_000;
  localparam logic [6:0] C_LDUSE  = 7'b1100_010;
  localparam logic [6:0] C_BRANCH = 7'b0000_110;
  localparam logic [6:0] C_MULDIV = 7'b1110_001;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    {deRs1Addr, deRs2Addr, exRdAddr, memRdAddr, wbRdAddr} = '0;
    {deUsesRs1, deUsesRs2, exRdWriteEn, exLoadSignal, exBranchTaken} = '0;
    {exMulDivStart, mulDivDone, memRdWriteEn, memAccess, dmemRvalid, wbRdWriteEn} = '0;
  endtask

  // advance one clock, land 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    clr();
    reset = 1'b1;
    tick();
    #1;
    reset = 1'b0;
    #1;
  endtask

  // lw x5 in EX, add x6,x5,x1 in DE
  task automatic setLoadUse();
    exLoadSignal = 1'b1; exRdWriteEn = 1'b1; exRdAddr = 5'd5;
    deRs1Addr = 5'd5; deRs2Addr = 5'd1; deUsesRs1 = 1'b1; deUsesRs2 = 1'b1;
  endtask

  initial begin
    clr();
    reset = 1'b1;
    // forwarding candidate present during reset must stay 00
    memRdAddr = 5'd5; memRdWriteEn = 1'b1; deRs1Addr = 5'd5;
    tick();
    chk("rst_ctl",   ctl,        C_RST);
    chk("rst_fwdA",  fwdASelect, 2'b00);
    chk("rst_state", ctrlState,  2'b00);
    chk("rst_berr",  busError,   1'b0);
    clr();
    reset = 1'b0;
    #1;
    chk("run_idle", ctl, C_NONE);

    // 1: load-use -> exactly one bubble, then WB forwarding
    setLoadUse();
    #1;
    chk("lu_ctl", ctl, C_LDUSE);
    tick();
    chk("lu_state", ctrlState, 2'b00);
    clr();
    deRs1Addr = 5'd5; deRs2Addr = 5'd1; deUsesRs1 = 1'b1; deUsesRs2 = 1'b1;
    wbRdAddr = 5'd5; wbRdWriteEn = 1'b1;
    #1;
    chk("lu_after_ctl", ctl,        C_NONE);
    chk("lu_fwdA",      fwdASelect, 2'b10);
    chk("lu_fwdB",      fwdBSelect, 2'b00);

    // 2: back-to-back ALU dependency; MEM beats WB; x0 never forwarded
    clr();
    deRs1Addr = 5'd5; deRs2Addr = 5'd5; deUsesRs1 = 1'b1; deUsesRs2 = 1'b1;
    memRdAddr = 5'd5; memRdWriteEn = 1'b1; wbRdAddr = 5'd5; wbRdWriteEn = 1'b1;
    #1;
    chk("fwd_memA", fwdASelect, 2'b01);
    chk("fwd_memB", fwdBSelect, 2'b01);
    memRdWriteEn = 1'b0;
    #1;
    chk("fwd_wbA", fwdASelect, 2'b10);
    deRs1Addr = 5'd0; deRs2Addr = 5'd0; memRdAddr = 5'd0; memRdWriteEn = 1'b1; wbRdAddr = 5'd0;
    #1;
    chk("fwd_x0A", fwdASelect, 2'b00);
    chk("fwd_x0B", fwdBSelect, 2'b00);
    deRs2Addr = 5'd7; memRdAddr = 5'd9; wbRdAddr = 5'd7;
    #1;
    chk("fwd_wbB", fwdBSelect, 2'b10);

    // 3: taken branch wins over load-use
    clr();
    setLoadUse();
    exBranchTaken = 1'b1;
    #1;
    chk("br_ctl", ctl, C_BRANCH);
    tick();
    clr();
    #1;
    chk("br_next_ctl",   ctl,       C_NONE);
    chk("br_next_state", ctrlState, 2'b00);

    // 4: memory wait 3 cycles, release on 4th with RUN rules applied
    clr();
    memAccess = 1'b1;
    #1;
    chk("mw_c1_ctl", ctl, C_FREEZE);
    tick();
    chk("mw_c2_state", ctrlState, 2'b01);
    exBranchTaken = 1'b1;  // frozen: ignored
    #1;
    chk("mw_c2_ctl", ctl, C_FREEZE);
    tick();
    exBranchTaken = 1'b0;
    #1;
    chk("mw_c3_ctl",   ctl,       C_FREEZE);
    chk("mw_c3_state", ctrlState, 2'b01);
    tick();
    dmemRvalid = 1'b1;
    setLoadUse();
    #1;
    chk("mw_rel_ctl", ctl, C_LDUSE);
    tick();
    chk("mw_rel_state", ctrlState, 2'b00);

    // 6: divide, done after 33 stall cycles
    clr();
    exMulDivStart = 1'b1;
    #1;
    chk("md_c1_ctl", ctl, C_MULDIV);
    tick();
    begin
      int okCycles = 0;
      for (int i = 2; i <= 33; i++) begin
        if (ctl == C_MULDIV && ctrlState == 2'b10) okCycles++;
        tick();
      end
      chk("md_wait_cycles", okCycles, 32);
    end
    mulDivDone = 1'b1;
    #1;
    chk("md_rel_ctl",   ctl,       C_NONE);
    chk("md_rel_state", ctrlState, 2'b10);
    tick();
    exMulDivStart = 1'b0; mulDivDone = 1'b0;
    chk("md_done_state", ctrlState, 2'b00);

    // 5: timeout with TIMEOUT_W=4 -> ERROR after 15 wait cycles
    clr();
    memAccess = 1'b1;
    begin
      int okCycles = 0;
      for (int i = 1; i <= 14; i++) begin
        #1;
        if (ctl == C_FREEZE) okCycles++;
        tick();
      end
      chk("to_freeze_cycles", okCycles, 14);
    end
    chk("to_c14_state", ctrlState, 2'b01);
    chk("to_c14_berr",  busError,  1'b0);
    tick();
    chk("to_err_state", ctrlState, 2'b11);
    chk("to_err_berr",  busError,  1'b1);
    clr();
    dmemRvalid = 1'b1;
    tick();
    tick();
    chk("err_sticky_state", ctrlState, 2'b11);
    chk("err_sticky_berr",  busError,  1'b1);
    chk("err_ctl",          ctl,       C_FREEZE);

    // reset clears ERROR, busError and the counter
    doReset();
    chk("rst2_state", ctrlState, 2'b00);
    chk("rst2_berr",  busError,  1'b0);
    memAccess = 1'b1;
    for (int i = 1; i <= 14; i++) tick();
    chk("rst2_cnt_state", ctrlState, 2'b01);

    // reset mid-wait returns to RUN at once
    reset = 1'b1;
    #1;
    chk("rst_mid_state", ctrlState, 2'b00);
    chk("rst_mid_ctl",   ctl,       C_RST);
    reset = 1'b0;
    clr();
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
